multicycle_step_controller: RTL and testbench

//  Sequencing control unit for the multicycle register/ALU datapath.
//  - Owns its own step counter (T0..T3) and a run/busy/done handshake; no external timestep input.
//  - Decodes the instruction register and drives the register file, A/G registers, ALU, IR and immediate bus.
//  - Generalised in data width and register count; adds sign-extended immediates, a stall input and illegal-opcode trapping.

---
 rtl/multicycle_step_controller.sv | 258 +++++++++++++++++++++++++
 tb/tb_multicycle_step_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_step_controller.sv
// ---------------------------------------------------------------------------
// multicycle_step_controller
//
// Sequencing control unit for the multicycle register/ALU datapath. It keeps
// its own two-bit step counter (T0..T3), accepts a start request in T0,
// decodes the instruction register and drives the register file, the A/G
// registers, the ALU, the IR load and the immediate bus.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset; also forces all outputs to 0
//   run_i        start request, only looked at in T0
//   hold_i       stall; freezes the step and suppresses loads in T1..T3
//   INSTR_i      instruction register contents, valid from T1 onward
//   IMM_o        immediate value (zero- or sign-extended) for the bus
//   IMMout_o     IMM_o drives the bus this cycle
//   Rin_o        register-file write address
//   Rout_o       register-file read address
//   ENW_o        register-file write enable
//   ENR_o        register-file read enable
//   Ain_o        A register load
//   Gin_o        G register load
//   Gout_o       G register drives the bus
//   ALUcont_o    ALU operation code
//   Ext_o        external data onto the bus
//   IRin_o       instruction register load
//   busy_o       instruction in flight (T1..T3)
//   done_o       one-cycle pulse in the final step of an instruction
//   err_o        one-cycle pulse on an illegal opcode
//   step_o       current step, for debug
//
// Parameters
//   INSTR_W must be at least 2*REG_AW+6 so that rx, ry and FN fit below the
//   imm/isub flag bits. NREG must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module multicycle_step_controller #(
  parameter int INSTR_W      = 10,
  parameter int DATA_W       = 10,
  parameter int NREG         = 4,
  parameter bit SIGN_EXT_IMM = 1'b0,
  localparam int REG_AW      = $clog2(NREG)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                run_i,
  input  logic                hold_i,
  input  logic [INSTR_W-1:0]  INSTR_i,
  output logic [DATA_W-1:0]   IMM_o,
  output logic                IMMout_o,
  output logic [REG_AW-1:0]   Rin_o,
  output logic [REG_AW-1:0]   Rout_o,
  output logic                ENW_o,
  output logic                ENR_o,
  output logic                Ain_o,
  output logic                Gin_o,
  output logic                Gout_o,
  output logic [3:0]          ALUcont_o,
  output logic                Ext_o,
  output logic                IRin_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          step_o
);

  // The immediate field spans everything below the imm/isub/rx fields.
  localparam int IMMV_W = INSTR_W - 2 - REG_AW;

  localparam logic [3:0] FN_LOAD = 4'h0;
  localparam logic [3:0] FN_COPY = 4'h1;
  localparam logic [3:0] FN_ADD  = 4'h2;
  localparam logic [3:0] FN_SUB  = 4'h3;
  localparam logic [3:0] FN_INV  = 4'h4;
  localparam logic [3:0] FN_FLP  = 4'h5;
  localparam logic [3:0] FN_AND  = 4'h6;
  localparam logic [3:0] FN_OR   = 4'h7;
  localparam logic [3:0] FN_XOR  = 4'h8;
  localparam logic [3:0] FN_LSL  = 4'h9;
  localparam logic [3:0] FN_LSR  = 4'hA;
  localparam logic [3:0] FN_ASR  = 4'hB;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  step_e step_q;
  step_e step_d;

  logic              isImm;
  logic              isSub;
  logic [REG_AW-1:0] rx;
  logic [REG_AW-1:0] ry;
  logic [3:0]        fn;
  logic [IMMV_W-1:0] immv;
  logic [DATA_W-1:0] immExt;
  logic              isUnary;
  logic              isBinary;

  // Instruction field extraction.
  assign isImm = INSTR_i[INSTR_W-1];
  assign isSub = INSTR_i[INSTR_W-2];
  assign rx    = INSTR_i[2*REG_AW+3 : REG_AW+4];
  assign ry    = INSTR_i[REG_AW+3 : 4];
  assign fn    = INSTR_i[3:0];
  assign immv  = INSTR_i[IMMV_W-1:0];

  // Opcode classes. Everything from C to F falls in neither class and traps.
  assign isUnary  = (fn == FN_INV) || (fn == FN_FLP);
  assign isBinary = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                    (fn == FN_OR)  || (fn == FN_XOR) || (fn == FN_LSL) ||
                    (fn == FN_LSR) || (fn == FN_ASR);

  // Immediate extension to the datapath width; a field wider than the
  // datapath is simply truncated.
  generate
    if (IMMV_W >= DATA_W) begin : gImmTrunc
      assign immExt = immv[DATA_W-1:0];
    end else if (SIGN_EXT_IMM) begin : gImmSign
      assign immExt = {{(DATA_W-IMMV_W){immv[IMMV_W-1]}}, immv};
    end else begin : gImmZero
      assign immExt = {{(DATA_W-IMMV_W){1'b0}}, immv};
    end
  endgenerate

  // Step register. Reset returns to T0, abandoning any instruction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_q <= T0;
    end else begin
      step_q <= step_d;
    end
  end

  // Next-step and output decode. Everything defaults to 0; while rst_i is
  // high nothing is decoded, so all outputs stay 0. A hold outside T0 keeps
  // the step and strips every load/pulse, leaving addresses and reads visible.
  always_comb begin
    step_d    = step_q;
    IMM_o     = '0;
    IMMout_o  = 1'b0;
    Rin_o     = '0;
    Rout_o    = '0;
    ENW_o     = 1'b0;
    ENR_o     = 1'b0;
    Ain_o     = 1'b0;
    Gin_o     = 1'b0;
    Gout_o    = 1'b0;
    ALUcont_o = 4'h0;
    Ext_o     = 1'b0;
    IRin_o    = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    err_o     = 1'b0;
    step_o    = 2'd0;

    if (!rst_i) begin
      busy_o = (step_q != T0);
      step_o = step_q;

      case (step_q)
        T0: begin
          if (run_i) begin
            IRin_o = 1'b1;
            Ext_o  = 1'b1;
            step_d = T1;
          end
        end

        T1: begin
          if (isImm) begin
            Rout_o = rx;
            ENR_o  = 1'b1;
            Ain_o  = 1'b1;
            step_d = T2;
          end else if (fn == FN_LOAD) begin
            Ext_o  = 1'b1;
            Rin_o  = rx;
            ENW_o  = 1'b1;
            done_o = 1'b1;
            step_d = T0;
          end else if (fn == FN_COPY) begin
            Rout_o = ry;
            ENR_o  = 1'b1;
            Rin_o  = rx;
            ENW_o  = 1'b1;
            done_o = 1'b1;
            step_d = T0;
          end else if (isUnary) begin
            Rout_o    = ry;
            ENR_o     = 1'b1;
            Gin_o     = 1'b1;
            ALUcont_o = fn;
            step_d    = T2;
          end else if (isBinary) begin
            Rout_o = rx;
            ENR_o  = 1'b1;
            Ain_o  = 1'b1;
            step_d = T2;
          end else begin
            err_o  = 1'b1;
            step_d = T0;
          end
        end

        T2: begin
          if (isImm) begin
            IMM_o     = immExt;
            IMMout_o  = 1'b1;
            Gin_o     = 1'b1;
            ALUcont_o = isSub ? FN_SUB : FN_ADD;
            step_d    = T3;
          end else if (isUnary) begin
            Gout_o = 1'b1;
            Rin_o  = rx;
            ENW_o  = 1'b1;
            done_o = 1'b1;
            step_d = T0;
          end else if (isBinary) begin
            Rout_o    = ry;
            ENR_o     = 1'b1;
            Gin_o     = 1'b1;
            ALUcont_o = fn;
            step_d    = T3;
          end else begin
            // Only reachable if the IR changed under us; recover to idle.
            step_d = T0;
          end
        end

        T3: begin
          Gout_o = 1'b1;
          Rin_o  = rx;
          ENW_o  = 1'b1;
          done_o = 1'b1;
          step_d = T0;
        end

        default: begin
          step_d = T0;
        end
      endcase

      if (hold_i && (step_q != T0)) begin
        step_d = step_q;
        ENW_o  = 1'b0;
        Ain_o  = 1'b0;
        Gin_o  = 1'b0;
        IRin_o = 1'b0;
        done_o = 1'b0;
        err_o  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_step_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_step_controller
//
// Drives instruction sequences cycle by cycle into two controllers (sign- and
// zero-extended immediates). Each driven cycle pushes the expected output
// vector onto a queue; a negedge monitor pops it and compares.
// ---------------------------------------------------------------------------
module tb_multicycle_step_controller;

  localparam int INSTR_W = 10;
  localparam int DATA_W  = 10;
  localparam int NREG    = 4;

  typedef struct packed {
    logic [9:0] imm;
    logic       immOut;
    logic [1:0] rin;
    logic [1:0] rout;
    logic       enw;
    logic       enr;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [3:0] alu;
    logic       ext;
    logic       irin;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] step;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic hold = 1'b0;
  logic [INSTR_W-1:0] instr = '0;

  logic [DATA_W-1:0] immS, immZ;
  logic immOutS, immOutZ;
  logic [1:0] rinS, rinZ, routS, routZ;
  logic enwS, enwZ, enrS, enrZ, ainS, ainZ, ginS, ginZ, goutS, goutZ;
  logic [3:0] aluS, aluZ;
  logic extS, extZ, irinS, irinZ, busyS, busyZ, doneS, doneZ, errS, errZ;
  logic [1:0] stepS, stepZ;

  outs_t observed;

  outs_t expQ[$];
  logic [9:0] immZQ[$];
  string tagQ[$];

  int testsRun = 0;
  int testsFailed = 0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  multicycle_step_controller #(
    .INSTR_W(INSTR_W), .DATA_W(DATA_W), .NREG(NREG), .SIGN_EXT_IMM(1'b1)
  ) dutSign (
    .clk_i(clk), .rst_i(rst), .run_i(run), .hold_i(hold), .INSTR_i(instr),
    .IMM_o(immS), .IMMout_o(immOutS), .Rin_o(rinS), .Rout_o(routS),
    .ENW_o(enwS), .ENR_o(enrS), .Ain_o(ainS), .Gin_o(ginS), .Gout_o(goutS),
    .ALUcont_o(aluS), .Ext_o(extS), .IRin_o(irinS), .busy_o(busyS),
    .done_o(doneS), .err_o(errS), .step_o(stepS)
  );

  multicycle_step_controller #(
    .INSTR_W(INSTR_W), .DATA_W(DATA_W), .NREG(NREG), .SIGN_EXT_IMM(1'b0)
  ) dutZero (
    .clk_i(clk), .rst_i(rst), .run_i(run), .hold_i(hold), .INSTR_i(instr),
    .IMM_o(immZ), .IMMout_o(immOutZ), .Rin_o(rinZ), .Rout_o(routZ),
    .ENW_o(enwZ), .ENR_o(enrZ), .Ain_o(ainZ), .Gin_o(ginZ), .Gout_o(goutZ),
    .ALUcont_o(aluZ), .Ext_o(extZ), .IRin_o(irinZ), .busy_o(busyZ),
    .done_o(doneZ), .err_o(errZ), .step_o(stepZ)
  );

  assign observed = {immS, immOutS, rinS, routS, enwS, enrS, ainS, ginS, goutS,
                     aluS, extS, irinS, busyS, doneS, errS, stepS};

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Wait for the next edge, drive the inputs for this cycle and queue what
  // the controllers should show while those inputs are applied.
  task automatic applyStimulus(input string tag, input logic r, input logic rn,
                               input logic h, input logic [9:0] ins,
                               input outs_t e, input logic [9:0] zImm);
    @(posedge clk);
    #1;
    rst   = r;
    run   = rn;
    hold  = h;
    instr = ins;
    expQ.push_back(e);
    immZQ.push_back(zImm);
    tagQ.push_back(tag);
  endtask

  // Scoreboard: compare one queued expectation per cycle, mid-cycle.
  always @(negedge clk) begin
    outs_t e;
    logic [9:0] z;
    string tag;
    if (expQ.size() > 0) begin
      e   = expQ.pop_front();
      z   = immZQ.pop_front();
      tag = tagQ.pop_front();
      checkOutput(tag, 32'(observed), 32'(e));
      checkOutput({tag, "/immZero"}, 32'(immZ), 32'(z));
    end
  end

  function automatic outs_t idle();
    idle = '0;
  endfunction

  function automatic outs_t fetch();
    fetch = '0;
    fetch.irin = 1'b1;
    fetch.ext  = 1'b1;
  endfunction

  function automatic outs_t at(input logic [1:0] st);
    at = '0;
    at.step = st;
    at.busy = 1'b1;
  endfunction

  initial begin
    outs_t e;

    // Reset with run high: everything quiet; fetch right after release.
    applyStimulus("rst0", 1, 1, 0, 10'h080, idle(), 10'h0);
    applyStimulus("rst1", 1, 1, 0, 10'h080, idle(), 10'h0);
    applyStimulus("ldFetch", 0, 1, 0, 10'h080, fetch(), 10'h0);
    e = at(1); e.ext = 1; e.rin = 2; e.enw = 1; e.done = 1;
    applyStimulus("ldT1", 0, 0, 0, 10'h080, e, 10'h0);
    applyStimulus("ldIdle", 0, 0, 0, 10'h080, idle(), 10'h0);

    // ADD r1,r2; run left high in T1 is ignored.
    applyStimulus("addFetch", 0, 1, 0, 10'h062, fetch(), 10'h0);
    e = at(1); e.rout = 1; e.enr = 1; e.ain = 1;
    applyStimulus("addT1", 0, 1, 0, 10'h062, e, 10'h0);
    e = at(2); e.rout = 2; e.enr = 1; e.gin = 1; e.alu = 4'h2;
    applyStimulus("addT2", 0, 0, 0, 10'h062, e, 10'h0);
    e = at(3); e.gout = 1; e.rin = 1; e.enw = 1; e.done = 1;
    applyStimulus("addT3", 0, 0, 0, 10'h062, e, 10'h0);
    applyStimulus("addIdle", 0, 0, 0, 10'h062, idle(), 10'h0);

    // SUB-imm r0,#-1: sign-extended 3FF vs zero-extended 03F.
    applyStimulus("subiFetch", 0, 1, 0, 10'h33F, fetch(), 10'h0);
    e = at(1); e.rout = 0; e.enr = 1; e.ain = 1;
    applyStimulus("subiT1", 0, 0, 0, 10'h33F, e, 10'h0);
    e = at(2); e.imm = 10'h3FF; e.immOut = 1; e.gin = 1; e.alu = 4'h3;
    applyStimulus("subiT2", 0, 0, 0, 10'h33F, e, 10'h03F);
    e = at(3); e.gout = 1; e.rin = 0; e.enw = 1; e.done = 1;
    applyStimulus("subiT3", 0, 0, 0, 10'h33F, e, 10'h0);

    // ADD-imm r3,#0x25 straight after: sign 3E5, zero 025.
    applyStimulus("addiFetch", 0, 1, 0, 10'h2E5, fetch(), 10'h0);
    e = at(1); e.rout = 3; e.enr = 1; e.ain = 1;
    applyStimulus("addiT1", 0, 0, 0, 10'h2E5, e, 10'h0);
    e = at(2); e.imm = 10'h3E5; e.immOut = 1; e.gin = 1; e.alu = 4'h2;
    applyStimulus("addiT2", 0, 0, 0, 10'h2E5, e, 10'h025);
    e = at(3); e.gout = 1; e.rin = 3; e.enw = 1; e.done = 1;
    applyStimulus("addiT3", 0, 0, 0, 10'h2E5, e, 10'h0);

    // LOAD r0 back to back with run held high.
    applyStimulus("b2bFetchA", 0, 1, 0, 10'h000, fetch(), 10'h0);
    e = at(1); e.ext = 1; e.rin = 0; e.enw = 1; e.done = 1;
    applyStimulus("b2bLoadA", 0, 1, 0, 10'h000, e, 10'h0);
    applyStimulus("b2bFetchB", 0, 1, 0, 10'h000, fetch(), 10'h0);
    applyStimulus("b2bLoadB", 0, 0, 0, 10'h000, e, 10'h0);

    // COPY r3,r1.
    applyStimulus("cpyFetch", 0, 1, 0, 10'h0D1, fetch(), 10'h0);
    e = at(1); e.rout = 1; e.enr = 1; e.rin = 3; e.enw = 1; e.done = 1;
    applyStimulus("cpyT1", 0, 0, 0, 10'h0D1, e, 10'h0);

    // Illegal FN=D traps in T1 and returns to idle.
    applyStimulus("illFetch", 0, 1, 0, 10'h00D, fetch(), 10'h0);
    e = at(1); e.err = 1;
    applyStimulus("illT1", 0, 0, 0, 10'h00D, e, 10'h0);
    applyStimulus("illIdle", 0, 0, 0, 10'h00D, idle(), 10'h0);

    // INV r1,r3: hold ignored in T0, honoured in T1.
    applyStimulus("invFetchHold", 0, 1, 1, 10'h074, fetch(), 10'h0);
    e = at(1); e.rout = 3; e.enr = 1; e.alu = 4'h4;
    applyStimulus("invT1Hold", 0, 0, 1, 10'h074, e, 10'h0);
    e.gin = 1;
    applyStimulus("invT1", 0, 0, 0, 10'h074, e, 10'h0);
    e = at(2); e.gout = 1; e.rin = 1; e.enw = 1; e.done = 1;
    applyStimulus("invT2", 0, 0, 0, 10'h074, e, 10'h0);

    // XOR r2,r0.
    applyStimulus("xorFetch", 0, 1, 0, 10'h088, fetch(), 10'h0);
    e = at(1); e.rout = 2; e.enr = 1; e.ain = 1;
    applyStimulus("xorT1", 0, 0, 0, 10'h088, e, 10'h0);
    e = at(2); e.rout = 0; e.enr = 1; e.gin = 1; e.alu = 4'h8;
    applyStimulus("xorT2", 0, 0, 0, 10'h088, e, 10'h0);
    e = at(3); e.gout = 1; e.rin = 2; e.enw = 1; e.done = 1;
    applyStimulus("xorT3", 0, 0, 0, 10'h088, e, 10'h0);

    // ADD r1,r2 with a three-cycle stall in T2 and one in T3.
    applyStimulus("hldFetch", 0, 1, 0, 10'h062, fetch(), 10'h0);
    e = at(1); e.rout = 1; e.enr = 1; e.ain = 1;
    applyStimulus("hldT1", 0, 0, 0, 10'h062, e, 10'h0);
    e = at(2); e.rout = 2; e.enr = 1; e.alu = 4'h2;
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("hldT2s%0d", i), 0, 0, 1, 10'h062, e, 10'h0);
    end
    e.gin = 1;
    applyStimulus("hldT2", 0, 0, 0, 10'h062, e, 10'h0);
    e = at(3); e.gout = 1; e.rin = 1;
    applyStimulus("hldT3s", 0, 0, 1, 10'h062, e, 10'h0);
    e.enw = 1; e.done = 1;
    applyStimulus("hldT3", 0, 0, 0, 10'h062, e, 10'h0);

    // Reset in the middle of T2 abandons the instruction without done.
    applyStimulus("abFetch", 0, 1, 0, 10'h062, fetch(), 10'h0);
    e = at(1); e.rout = 1; e.enr = 1; e.ain = 1;
    applyStimulus("abT1", 0, 0, 0, 10'h062, e, 10'h0);
    applyStimulus("abRst", 1, 0, 0, 10'h062, idle(), 10'h0);
    applyStimulus("abIdle", 0, 0, 0, 10'h062, idle(), 10'h0);
    applyStimulus("abIdle2", 0, 0, 0, 10'h062, idle(), 10'h0);

    @(negedge clk);
    #1;
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
